// File: rtl/pc_unit.sv
// pc_unit: program counter with run/halt FSM, single-step gating, redirect
// priority (stall > halt > jump > branch > increment) and a saturating
// counter of PC advances.
module pc_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int INCR       = 1,
    parameter int RESET_PC   = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_step_mode,
    input  logic                  i_step,
    input  logic                  i_stall,
    input  logic                  i_jump,
    input  logic [DATA_WIDTH-1:0] i_jump_addr,
    input  logic                  i_branch,
    input  logic [DATA_WIDTH-1:0] i_branch_addr,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_incr,
    output logic                  o_halted,
    output logic [CNT_WIDTH-1:0]  o_adv_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    localparam logic [DATA_WIDTH-1:0] PC_RST  = DATA_WIDTH'(RESET_PC);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INCR);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  adv_slot;
    logic                  pc_load;
    logic [DATA_WIDTH-1:0] pc_plus;

    // Sequential-step adder; wraps naturally at the port width.
    assign pc_plus  = pc_q + PC_STEP;

    // A slot exists only while running, enabled and either free-running or stepped.
    assign adv_slot = i_enable && (state_q == RUN) && (!i_step_mode || i_step);

    // Next-state, next-PC and advance-counter selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        pc_load = 1'b0;
        if (adv_slot) begin
            if (i_stall) begin
                // Redirects presented with a stall are dropped, not queued.
                pc_d = pc_q;
            end else if (i_halt) begin
                state_d = HALTED;
            end else if (i_jump) begin
                pc_d    = i_jump_addr;
                pc_load = 1'b1;
            end else if (i_branch) begin
                pc_d    = i_branch_addr;
                pc_load = 1'b1;
            end else begin
                pc_d    = pc_plus;
                pc_load = 1'b1;
            end
        end
        if (pc_load && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, PC and counter registers; reset is asynchronous and overrides HALTED.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            pc_q    <= PC_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc        = pc_q;
    assign o_pc_incr   = pc_plus;
    assign o_halted    = (state_q == HALTED);
    assign o_adv_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a default 32-bit instance plus an 8-bit
// instance with a 2-bit counter for wrap and saturation cases.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, step_mode, step, stall, jump, branch, halt;
    logic [31:0] jaddr, baddr;

    logic [31:0] pc, pc_incr, cnt;
    logic        halted;
    logic [7:0]  pc8, pc_incr8;
    logic [1:0]  cnt8;
    logic        halted8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_jump(jump), .i_jump_addr(jaddr),
        .i_branch(branch), .i_branch_addr(baddr), .i_halt(halt),
        .o_pc(pc), .o_pc_incr(pc_incr), .o_halted(halted), .o_adv_count(cnt)
    );

    pc_unit #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_step_mode(step_mode),
        .i_step(step), .i_stall(stall), .i_jump(jump), .i_jump_addr(jaddr[7:0]),
        .i_branch(branch), .i_branch_addr(baddr[7:0]), .i_halt(halt),
        .o_pc(pc8), .o_pc_incr(pc_incr8), .o_halted(halted8), .o_adv_count(cnt8)
    );

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 1'b1; step_mode = 1'b0; step = 1'b0; stall = 1'b0;
        jump = 1'b0; branch = 1'b0; halt = 1'b0; jaddr = '0; baddr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", pc); end
        checks++; if (pc_incr !== 32'd1) begin errors++; $display("FAIL reset_pc_incr got %0h want 1", pc_incr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
    endtask

    task automatic test_continuous();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (pc !== 32'(i)) begin errors++; $display("FAIL cont_pc step %0d got %0h want %0h", i, pc, i); end
        end
        checks++; if (cnt !== 32'd4) begin errors++; $display("FAIL cont_count got %0d want 4", cnt); end
        checks++; if (pc_incr !== 32'd5) begin errors++; $display("FAIL cont_pc_incr got %0h want 5", pc_incr); end
    endtask

    task automatic test_priority();
        do_reset();
        cycle(); cycle(); cycle();
        checks++; if (pc !== 32'd3) begin errors++; $display("FAIL prio_setup got %0h want 3", pc); end
        // stall with both redirects: hold, count unchanged
        stall = 1'b1; jump = 1'b1; jaddr = 32'h40; branch = 1'b1; baddr = 32'h80;
        cycle();
        checks++; if (pc !== 32'd3) begin errors++; $display("FAIL prio_stall_pc got %0h want 3", pc); end
        checks++; if (cnt !== 32'd3) begin errors++; $display("FAIL prio_stall_count got %0d want 3", cnt); end
        // jump beats branch
        stall = 1'b0;
        cycle();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL prio_jump_pc got %0h want 40", pc); end
        checks++; if (cnt !== 32'd4) begin errors++; $display("FAIL prio_jump_count got %0d want 4", cnt); end
        // branch alone
        jump = 1'b0;
        cycle();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL prio_branch_pc got %0h want 80", pc); end
        // enable low freezes everything
        branch = 1'b0; en = 1'b0;
        cycle();
        checks++; if (pc !== 32'h80 || cnt !== 32'd5) begin
            errors++; $display("FAIL prio_disable got pc %0h cnt %0d want 80 5", pc, cnt);
        end
        en = 1'b1;
    endtask

    task automatic test_step();
        logic [5:0] pattern;
        do_reset();
        step_mode = 1'b1;
        pattern = 6'b010010;
        for (int i = 0; i < 6; i++) begin
            step = pattern[i];
            cycle();
        end
        step = 1'b0;
        checks++; if (pc !== 32'd2) begin errors++; $display("FAIL step_pc got %0h want 2", pc); end
        checks++; if (cnt !== 32'd2) begin errors++; $display("FAIL step_count got %0d want 2", cnt); end
        // held step: one advance per cycle
        step = 1'b1;
        cycle(); cycle(); cycle();
        step = 1'b0;
        checks++; if (pc !== 32'd5) begin errors++; $display("FAIL step_held_pc got %0h want 5", pc); end
        step_mode = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        jump = 1'b1; jaddr = 32'd7;
        cycle();
        jump = 1'b0;
        checks++; if (pc !== 32'd7) begin errors++; $display("FAIL halt_setup got %0h want 7", pc); end
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        checks++; if (pc !== 32'd7) begin errors++; $display("FAIL halt_pc got %0h want 7", pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", halted); end
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL halt_count got %0d want 1", cnt); end
        jump = 1'b1; jaddr = 32'h55; step_mode = 1'b1; step = 1'b1;
        cycle(); cycle();
        jump = 1'b0; step_mode = 1'b0; step = 1'b0;
        cycle();
        checks++; if (pc !== 32'd7 || halted !== 1'b1 || cnt !== 32'd1) begin
            errors++; $display("FAIL halt_ignore got pc %0h halted %b cnt %0d want 7 1 1", pc, halted, cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_reset got pc %0h halted %b want 0 0", pc, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++; if (pc !== 32'd1) begin errors++; $display("FAIL halt_resume got %0h want 1", pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        jump = 1'b1; jaddr = 32'hFF;
        cycle();
        jump = 1'b0;
        checks++; if (pc8 !== 8'hFF) begin errors++; $display("FAIL wrap_setup got %0h want ff", pc8); end
        checks++; if (pc_incr8 !== 8'h00) begin errors++; $display("FAIL wrap_incr got %0h want 00", pc_incr8); end
        cycle();
        checks++; if (pc8 !== 8'h00) begin errors++; $display("FAIL wrap_pc got %0h want 00", pc8); end
        checks++; if (cnt8 !== 2'd2) begin errors++; $display("FAIL wrap_count got %0d want 2", cnt8); end
        cycle(); cycle();
        checks++; if (pc8 !== 8'h02 || cnt8 !== 2'd3) begin
            errors++; $display("FAIL sat_count got pc %0h cnt %0d want 02 3", pc8, cnt8);
        end
        checks++; if (halted8 !== 1'b0) begin errors++; $display("FAIL wrap_halted got %b want 0", halted8); end
    endtask

    task automatic test_async_reset();
        do_reset();
        jump = 1'b1; jaddr = 32'h20;
        cycle();
        jump = 1'b0; en = 1'b0;
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL async_setup got %0h want 20", pc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'd0 || cnt !== 32'd0) begin
            errors++; $display("FAIL async_reset got pc %0h cnt %0d want 0 0", pc, cnt);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_priority();
        test_step();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
